// File: rtl/vdp_bus_pkg.sv
// Shared types and helpers for the CPU-to-VDP host bus bridge.
//   issue_state_t : issue-side FSM states
//   VDP_ADR_W     : width of the VDP core address port
//   bitrev()      : reverse the low w bits of a word (pin order <-> bit order)
package vdp_bus_pkg;

  localparam int unsigned VDP_ADR_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    WR_REQ,
    RD_REQ,
    RD_HOLD
  } issue_state_t;

  function automatic logic [31:0] bitrev(input logic [31:0] d, input int unsigned w);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < w) r[5'(i)] = d[5'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/vdp_sync_fifo.sv
// Synchronous FIFO holding posted writes.
//   clk, rst_n_w  : clock, asynchronous active-low reset (empties the FIFO)
//   push, din     : write an entry (ignored when full)
//   pop, dout     : dout shows the head; pop removes it (ignored when empty)
//   full, empty   : occupancy flags
//   level         : number of occupied entries
module vdp_sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n_w,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n_w) begin
    if (!rst_n_w) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/vdp_cpu_bus_bridge.sv
// CPU-to-VDP host bus bridge with posted writes.
// Synchronises and glitch-filters csr_n/csw_n, queues writes in a FIFO, and
// issues req/ack transactions to the VDP core; reads wait for prior writes.
//   clk, rst_n_w          : clock, asynchronous active-low reset
//   csr_n, csw_n          : async CPU read/write strobes
//   mode, cd_in           : async register select and data pins (pin order)
//   cd_out, cd_oe         : read data (pin order) and pin driver enable
//   vdp_req/wrt/adr/dbo   : request to VDP core
//   vdp_dbi, vdp_ack      : read data and accept from VDP core
//   fifo_level            : occupied posted-write entries
//   overflow, proto_err   : sticky error flags, cleared by err_clr
module vdp_cpu_bus_bridge
  import vdp_bus_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 2,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter bit          BIT_REVERSE = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n_w,
  input  logic                          csr_n,
  input  logic                          csw_n,
  input  logic [ADDR_W-1:0]             mode,
  input  logic [DATA_W-1:0]             cd_in,
  output logic [DATA_W-1:0]             cd_out,
  output logic                          cd_oe,
  output logic                          vdp_req,
  output logic                          vdp_wrt,
  output logic [15:0]                   vdp_adr,
  output logic [DATA_W-1:0]             vdp_dbo,
  input  logic [DATA_W-1:0]             vdp_dbi,
  input  logic                          vdp_ack,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          proto_err,
  input  logic                          err_clr
);

  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

  logic [SYNC_STAGES-1:0] csr_sync, csw_sync;
  logic [ENTRY_W-1:0]     dat_sync [SYNC_STAGES];
  logic                   csr_f, csw_f, csr_fn, csw_fn;
  logic                   blocked, both_low, quiet, wr_evt, rd_evt;
  logic [ADDR_W-1:0]      mode_last, rd_adr;
  logic [DATA_W-1:0]      cd_last, cd_logical, rd_data;
  logic [ENTRY_W-1:0]     wr_hold, fifo_dout;
  logic                   fifo_full, fifo_empty, pop, start_rd, rd_done, rd_pend;
  issue_state_t           state, state_nx;

  for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_csr
    always_ff @(posedge clk or negedge rst_n_w) begin
      if (!rst_n_w) csr_sync[g] <= 1'b1;
      else if (g == 0) csr_sync[g] <= csr_n;
      else csr_sync[g] <= csr_sync[(g == 0) ? 0 : g - 1];
    end
  end

  for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_csw
    always_ff @(posedge clk or negedge rst_n_w) begin
      if (!rst_n_w) csw_sync[g] <= 1'b1;
      else if (g == 0) csw_sync[g] <= csw_n;
      else csw_sync[g] <= csw_sync[(g == 0) ? 0 : g - 1];
    end
  end

  // mode/cd travel through a chain of equal depth so the last stage lines up with the strobes.
  for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_dat
    always_ff @(posedge clk or negedge rst_n_w) begin
      if (!rst_n_w) dat_sync[g] <= '1;
      else if (g == 0) dat_sync[g] <= {mode, cd_in};
      else dat_sync[g] <= dat_sync[(g == 0) ? 0 : g - 1];
    end
  end

  assign {mode_last, cd_last} = dat_sync[SYNC_STAGES-1];
  assign cd_logical = BIT_REVERSE ? DATA_W'(bitrev(32'(cd_last), DATA_W)) : cd_last;
  assign cd_out     = BIT_REVERSE ? DATA_W'(bitrev(32'(rd_data), DATA_W)) : rd_data;
  assign cd_oe      = ~csr_n;

  // Filtered strobe moves only when every synchroniser stage agrees.
  assign csr_fn = (&csr_sync) ? 1'b1 : (~|csr_sync) ? 1'b0 : csr_f;
  assign csw_fn = (&csw_sync) ? 1'b1 : (~|csw_sync) ? 1'b0 : csw_f;

  // Once both strobes are seen low, all edges are suppressed until both are high again.
  assign both_low = ~csr_fn & ~csw_fn;
  assign quiet    = ~both_low & ~blocked;
  assign wr_evt   = quiet & ~csw_f & csw_fn;
  assign rd_evt   = quiet & csr_f & ~csr_fn;

  always_ff @(posedge clk or negedge rst_n_w) begin
    if (!rst_n_w) begin
      csr_f     <= 1'b1;
      csw_f     <= 1'b1;
      blocked   <= 1'b0;
      wr_hold   <= '0;
      rd_adr    <= '0;
      rd_pend   <= 1'b0;
      rd_data   <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
      vdp_adr   <= '0;
      vdp_dbo   <= '0;
      state     <= IDLE;
    end else begin
      csr_f <= csr_fn;
      csw_f <= csw_fn;
      if (both_low) blocked <= 1'b1;
      else if (csr_fn & csw_fn) blocked <= 1'b0;
      // Keep the last sample seen while the write strobe was low.
      if (!csw_sync[SYNC_STAGES-1]) wr_hold <= {mode_last, cd_logical};
      if (rd_evt) rd_adr <= mode_last;
      if (rd_done) begin
        rd_pend <= 1'b0;
        rd_data <= vdp_dbi;
      end
      if (rd_evt) rd_pend <= 1'b1;
      if (wr_evt & fifo_full) overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (both_low) proto_err <= 1'b1;
      else if (err_clr) proto_err <= 1'b0;
      if (pop) begin
        vdp_adr <= VDP_ADR_W'(fifo_dout[ENTRY_W-1:DATA_W]);
        vdp_dbo <= fifo_dout[DATA_W-1:0];
      end else if (start_rd) begin
        vdp_adr <= VDP_ADR_W'(rd_adr);
      end
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    vdp_req  = 1'b0;
    vdp_wrt  = 1'b0;
    pop      = 1'b0;
    start_rd = 1'b0;
    rd_done  = 1'b0;
    case (state)
      IDLE: begin
        if (rd_pend && fifo_empty) begin
          start_rd = 1'b1;
          state_nx = RD_REQ;
        end else if (!fifo_empty) begin
          pop      = 1'b1;
          state_nx = WR_REQ;
        end
      end
      WR_REQ: begin
        vdp_req = 1'b1;
        vdp_wrt = 1'b1;
        if (vdp_ack) state_nx = IDLE;
      end
      RD_REQ: begin
        vdp_req = 1'b1;
        if (vdp_ack) begin
          rd_done  = 1'b1;
          state_nx = RD_HOLD;
        end
      end
      RD_HOLD: begin
        if (csr_f) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  vdp_sync_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n_w(rst_n_w),
    .push   (wr_evt),
    .pop    (pop),
    .din    (wr_hold),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

endmodule
